// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin sharing of one udp_send core; req->start in 2 clk, then WAIT for done/timeout and GAP.
// Requests latch into pend (repeats while pending are counted as drops); `define UDP_SCHED_PRIO_EN gives requester 0 strict priority.
module udp_tx_sched #(
  parameter int NREQ = 4,
  parameter int NSZ  = 7,
  parameter int GAP  = 96,
  parameter int TMO  = 65535,
  parameter int NG   = 7,
  parameter int NT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] pay_byte,
  input  logic [NSZ-1:0]    addr,
  input  logic              done,
  output logic              start,
  output logic [7:0]        payload,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   pend,
  output logic [15:0]       drop_cnt,
  output logic              tmo_err
);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NG-1:0] GAP_LAST = (GAP == 0) ? '0 : NG'(GAP - 1);
  localparam logic [NT-1:0] TMO_LAST = NT'(TMO - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAPS} state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   rr, rr_nx, pick, idx;
  logic            pick_vld;
  logic [NREQ-1:0] gnt_nx, clr, drops;
  logic [NG-1:0]   gcnt;
  logic [NT-1:0]   tcnt;
  logic            tmo_hit;
  logic [3:0]      ndrop;
  logic [16:0]     dsum;
  int              j;

  // Requesters read addr themselves; the scheduler never needs it.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    pick     = rr;
    pick_vld = 1'b0;
    idx      = '0;
    j        = 0;
    // Walk backwards so the nearest set flag after rr wins.
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = RW'(j);
      if (pend[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
`ifdef UDP_SCHED_PRIO_EN
    if (pend[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr;
    clr      = '0;
    start    = 1'b0;
    busy     = (state != IDLE);
    tmo_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = START;
          gnt_nx   = NREQ'(1) << pick;
          clr      = NREQ'(1) << pick;
`ifdef UDP_SCHED_PRIO_EN
          if (pick != '0) rr_nx = pick;
`else
          rr_nx = pick;
`endif
        end
      end
      START: begin
        start    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_nx = GAPS;
          gnt_nx   = '0;
        end else if (tcnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = GAPS;
          gnt_nx   = '0;
        end
      end
      GAPS: begin
        if (gcnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A request on the granting edge re-arms pend and is not a drop.
  always_comb begin
    drops = req & pend & ~clr;
    ndrop = '0;
    for (int i = 0; i < NREQ; i++) ndrop = ndrop + 4'(drops[i]);
    dsum = {1'b0, drop_cnt} + {13'd0, ndrop};
  end

  always_comb begin
    payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) payload = payload | pay_byte[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rr       <= RW'(NREQ - 1);
      pend     <= '0;
      drop_cnt <= '0;
      tmo_err  <= 1'b0;
      tcnt     <= '0;
      gcnt     <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      rr       <= rr_nx;
      pend     <= (pend & ~clr) | req;
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      if (tmo_hit) tmo_err <= 1'b1;
      tcnt     <= (state == WAIT) ? tcnt + NT'(1) : '0;
      gcnt     <= (state == GAPS) ? gcnt + NG'(1) : '0;
    end
  end
endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched (GAP=96, TMO=300); run with or without UDP_SCHED_PRIO_EN.
module tb_udp_tx_sched;
  localparam logic [31:0] PB = 32'h44332211;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] pay_byte = PB;
  logic [6:0]  addr = '0;
  logic        done = 1'b0;
  logic        start;
  logic [7:0]  payload;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  pend;
  logic [15:0] drop_cnt;
  logic        tmo_err;
  int          total = 0;
  int          bad = 0;

  udp_tx_sched #(.NREQ(4), .NSZ(7), .GAP(96), .TMO(300), .NG(7), .NT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pay_byte(pay_byte), .addr(addr),
    .done(done), .start(start), .payload(payload), .gnt(gnt), .busy(busy),
    .pend(pend), .drop_cnt(drop_cnt), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b1;
    cyc(2);
    total++; if (start !== 1'b0)    begin bad++; $display("FAIL rst_start got=%b want=0", start); end
    total++; if (gnt !== 4'b0)      begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (pend !== 4'b0)     begin bad++; $display("FAIL rst_pend got=%b want=0000", pend); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt); end
    total++; if (tmo_err !== 1'b0)  begin bad++; $display("FAIL rst_tmo got=%b want=0", tmo_err); end
    total++; if (payload !== 8'h00) begin bad++; $display("FAIL rst_payload got=%h want=00", payload); end
    req = '0; done = 1'b0; rst_n = 1'b1;
    cyc(1);
    total++; if (busy !== 1'b0 || pend !== 4'b0) begin bad++; $display("FAIL rst_release busy=%b pend=%b want 0/0000", busy, pend); end
  endtask

  task automatic test_round_robin();
    req = 4'b1111; cyc(1); req = '0;
    total++; if (pend !== 4'b1111) begin bad++; $display("FAIL rr_pend got=%b want=1111", pend); end
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (start !== 1'b1 || gnt !== 4'(1 << k) || payload !== 8'(8'h11 * (k + 1))) begin
        bad++; $display("FAIL rr_grant%0d start=%b gnt=%b pay=%h want 1/%b/%h", k, start, gnt, payload, 4'(1 << k), 8'(8'h11 * (k + 1)));
      end
      cyc(10); done = 1'b1; cyc(1); done = 1'b0;
      cyc(96);
      if (k < 3) cyc(1);
    end
    total++; if (busy !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL rr_idle busy=%b start=%b want 0/0", busy, start); end
    req = 4'b0001; cyc(1); req = '0; cyc(1);
    total++; if (start !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL rr_after3 start=%b gnt=%b want 1/0001", start, gnt); end
    cyc(10); done = 1'b1; cyc(1); done = 1'b0; cyc(96);
  endtask

  task automatic test_single();
    req = 4'b0100; cyc(1); req = '0;
    total++; if (pend !== 4'b0100 || gnt !== 4'b0) begin bad++; $display("FAIL single_n1 pend=%b gnt=%b want 0100/0000", pend, gnt); end
    cyc(1);
    total++; if (gnt !== 4'b0100 || start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_n2 gnt=%b start=%b busy=%b want 0100/1/1", gnt, start, busy); end
    total++; if (payload !== 8'h33 || pend !== 4'b0) begin bad++; $display("FAIL single_pay pay=%h pend=%b want 33/0000", payload, pend); end
    pay_byte[23:16] = 8'h5A; #1;
    total++; if (payload !== 8'h5A) begin bad++; $display("FAIL single_follow got=%h want=5a", payload); end
    pay_byte = PB;
    cyc(1);
    total++; if (start !== 1'b0 || gnt !== 4'b0100) begin bad++; $display("FAIL single_wait start=%b gnt=%b want 0/0100", start, gnt); end
    cyc(199); done = 1'b1; cyc(1); done = 1'b0;
    total++; if (gnt !== 4'b0 || busy !== 1'b1 || payload !== 8'h00) begin bad++; $display("FAIL single_gap gnt=%b busy=%b pay=%h want 0000/1/00", gnt, busy, payload); end
    cyc(95);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap95 busy=%b want 1", busy); end
    cyc(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_gap96 busy=%b want 0", busy); end
  endtask

  task automatic test_drops();
    req = 4'b0001; cyc(1); req = '0; cyc(1);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_gnt0 got=%b want=0001", gnt); end
    cyc(1);
    req = 4'b0010; cyc(1); req = '0;
    total++; if (pend !== 4'b0010 || drop_cnt !== 16'd0) begin bad++; $display("FAIL drop_first pend=%b drop=%0d want 0010/0", pend, drop_cnt); end
    for (int i = 0; i < 3; i++) begin
      req = 4'b0010; cyc(1); req = '0; cyc(1);
    end
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL drop_three got=%0d want=3", drop_cnt); end
    req = 4'b0001; cyc(1); req = '0;
    total++; if (pend !== 4'b0011 || drop_cnt !== 16'd3) begin bad++; $display("FAIL drop_granted_req pend=%b drop=%0d want 0011/3", pend, drop_cnt); end
    done = 1'b1; cyc(1); done = 1'b0; cyc(96);
    total++; if (busy !== 1'b0 || pend !== 4'b0011) begin bad++; $display("FAIL drop_idle busy=%b pend=%b want 0/0011", busy, pend); end
    req = 4'b0010; cyc(1); req = '0;
    total++; if (gnt !== 4'b0010 || pend !== 4'b0011 || drop_cnt !== 16'd3) begin bad++; $display("FAIL drop_reset_same gnt=%b pend=%b drop=%0d want 0010/0011/3", gnt, pend, drop_cnt); end
    cyc(1); done = 1'b1; cyc(1); done = 1'b0; cyc(96); cyc(1);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_next0 got=%b want=0001", gnt); end
    cyc(1); done = 1'b1; cyc(1); done = 1'b0; cyc(96); cyc(1);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL drop_next1 got=%b want=0010", gnt); end
    cyc(1); done = 1'b1; cyc(1); done = 1'b0; cyc(96);
    total++; if (busy !== 1'b0 || pend !== 4'b0) begin bad++; $display("FAIL drop_end busy=%b pend=%b want 0/0000", busy, pend); end
  endtask

  task automatic test_timeout();
    req = 4'b1000; cyc(1); req = '0; cyc(1);
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL tmo_gnt3 got=%b want=1000", gnt); end
    cyc(300); done = 1'b1; cyc(1); done = 1'b0;
    total++; if (tmo_err !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_done_same tmo=%b gnt=%b busy=%b want 0/0000/1", tmo_err, gnt, busy); end
    cyc(96);
    req = 4'b0100; cyc(1); req = '0; cyc(1);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL tmo_gnt2 got=%b want=0100", gnt); end
    cyc(1); req = 4'b0001; cyc(1); req = '0;
    cyc(298);
    total++; if (tmo_err !== 1'b0 || gnt !== 4'b0100) begin bad++; $display("FAIL tmo_before tmo=%b gnt=%b want 0/0100", tmo_err, gnt); end
    cyc(1);
    total++; if (tmo_err !== 1'b1 || gnt !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_hit tmo=%b gnt=%b busy=%b want 1/0000/1", tmo_err, gnt, busy); end
    done = 1'b1; cyc(1); done = 1'b0;
    total++; if (busy !== 1'b1 || start !== 1'b0) begin bad++; $display("FAIL tmo_gap_done busy=%b start=%b want 1/0", busy, start); end
    cyc(95);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle busy=%b want 0", busy); end
    cyc(1);
    total++; if (start !== 1'b1 || gnt !== 4'b0001 || tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_next start=%b gnt=%b tmo=%b want 1/0001/1", start, gnt, tmo_err); end
  endtask

  task automatic test_reset_mid();
    cyc(3); req = 4'b1000; cyc(1); req = '0;
    #2 rst_n = 1'b0; #1;
    total++; if (gnt !== 4'b0 || busy !== 1'b0 || start !== 1'b0 || payload !== 8'h00) begin bad++; $display("FAIL mid_outs gnt=%b busy=%b start=%b pay=%h want 0", gnt, busy, start, payload); end
    total++; if (pend !== 4'b0 || tmo_err !== 1'b0 || drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_state pend=%b tmo=%b drop=%0d want 0", pend, tmo_err, drop_cnt); end
    cyc(2); rst_n = 1'b1;
    req = 4'b0101; cyc(1); req = '0; cyc(1);
    total++; if (start !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL mid_regrant start=%b gnt=%b want 1/0001", start, gnt); end
  endtask

  task automatic test_prio();
    logic [3:0] exp_ord [3];
`ifdef UDP_SCHED_PRIO_EN
    exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0100; exp_ord[2] = 4'b0010;
`else
    exp_ord[0] = 4'b0100; exp_ord[1] = 4'b0001; exp_ord[2] = 4'b0010;
`endif
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc(1);
    req = 4'b0010; cyc(1); req = '0; cyc(1);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL prio_gnt1 got=%b want=0010", gnt); end
    cyc(1); req = 4'b0110; cyc(1); req = '0;
    done = 1'b1; cyc(1); done = 1'b0;
    req = 4'b0001; cyc(1); req = '0;
    total++; if (pend !== 4'b0111 || drop_cnt !== 16'd0) begin bad++; $display("FAIL prio_pend pend=%b drop=%0d want 0111/0", pend, drop_cnt); end
    cyc(95); cyc(1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (start !== 1'b1 || gnt !== exp_ord[k]) begin bad++; $display("FAIL prio_order%0d start=%b gnt=%b want 1/%b", k, start, gnt, exp_ord[k]); end
      cyc(1); done = 1'b1; cyc(1); done = 1'b0; cyc(96);
      if (k < 2) cyc(1);
    end
    total++; if (busy !== 1'b0 || pend !== 4'b0) begin bad++; $display("FAIL prio_end busy=%b pend=%b want 0/0000", busy, pend); end
  endtask

  task automatic test_saturate();
    req = 4'b0110; cyc(3);
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL sat_multi got=%0d want=3", drop_cnt); end
    req = 4'b1111; cyc(17000);
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffff", drop_cnt); end
    cyc(64);
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", drop_cnt); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_drops();
    test_timeout();
    test_reset_mid();
    test_prio();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Shares the single udp_send core between NREQ independent frame requesters, e.g. jitter-report frames, periodic status/heartbeat frames and config echo frames.
- Latches each requester's one-cycle start pulse into a pending flag and grants requesters in round-robin order.
- For each granted requester: issues one start pulse to udp_send, steers that requester's payload byte onto the core's payload input, waits for frame completion, then enforces an inter-frame gap.
- Sits between the measurement/report logic and udp_send; the RMII path is unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NSZ, 7, width of udp_send byte address.
- GAP, 96, idle clk cycles after frame completion before the next start (96 bit times at 100 Mb/s, 100 MHz clk).
- TMO, 65535, max clk cycles in WAIT before the frame is aborted.
- NG, 7, width of gap counter (must hold GAP).
- NT, 16, width of timeout counter (must hold TMO).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester start pulse, one clk wide.
- pay_byte  in  8*NREQ  requester i drives bits [8i+7:8i] = its payload byte at address addr.
- addr  in  NSZ  byte address from udp_send.
- done  in  1  one-cycle pulse from udp_send at end of frame.
- start  out  1  one-cycle start pulse to udp_send.
- payload  out  8  pay_byte slice of the granted requester.
- gnt  out  NREQ  one-hot grant; held from START through WAIT.
- busy  out  1  high whenever state is not IDLE.
- pend  out  NREQ  pending flags.
- drop_cnt  out  16  count of requests lost to an already-pending flag; saturates at 0xFFFF.
- tmo_err  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all of start/gnt/pend/drop_cnt/tmo_err/counters = 0, busy=0, payload=0.
- Pending: pend[i] sets on req[i]. pend[i] clears in the cycle START is entered for i.
  - req[i] arriving while pend[i]=1: drop_cnt+1.
  - req[i] arriving in the same cycle pend[i] is being cleared by grant: re-sets pend[i]; not a drop.
  - req[i] while requester i is granted (WAIT/GAP): sets pend[i] normally.
  - Multiple simultaneous drops in one cycle add the number of drops, with saturation.
- Round-robin: pointer rr is the last granted index, reset value NREQ-1. In IDLE with any pend set, grant the first set flag searching rr+1, rr+2, ... modulo NREQ. Update rr to the granted index.
- FSM:
  - IDLE: if any pend -> START (gnt loaded same edge).
  - START: start=1 for exactly this cycle -> WAIT.
  - WAIT: timeout counter counts up from 0.
    - done -> GAP, clear gnt.
    - counter reaches TMO-1 without done -> set tmo_err, clear gnt -> GAP (aborted frame not retried).
    - done in the same cycle as the timeout: treated as done; tmo_err not set.
  - GAP: gap counter counts GAP cycles, then -> IDLE. GAP=0 means -> IDLE on the next cycle.
- Latency: req[i] at cycle n with scheduler idle -> gnt at n+2, start high at n+2 (pend registered at n+1, START state at n+2).
- payload: combinational mux of pay_byte by gnt; 0 when gnt=0. addr is passed through only in the sense that requesters use it directly; the block does not modify addr.
- done outside WAIT: ignored.

Optional Feature:
- UDP_SCHED_PRIO_EN.
  - Defined: requester 0 has strict priority. In IDLE, if pend[0]=1 it is granted regardless of rr, and rr is not updated by a requester-0 grant. Others remain round-robin among themselves.
  - Undefined: pure round-robin over all NREQ as above.

Test Plan:
- Single request: req=4'b0100 at cycle 10, done 200 cycles after start -> gnt=4'b0100 and start pulse at cycle 12; payload follows pay_byte[23:16]; busy low 96 cycles after done.
- Round-robin: req=4'b1111 in one cycle -> grants in order 0,1,2,3, each separated by completion+96-cycle gap; the next req=4'b0001 after rr=3 is granted immediately.
- Drops: req[1] pulsed 3 times while pend[1]=1 and another frame is active -> drop_cnt=3; one frame for requester 1 follows. Preset drop_cnt near 0xFFFF and keep dropping -> holds at 0xFFFF.
- Timeout: TMO=100, done never asserted -> tmo_err=1 at 100 cycles after start; GAP then IDLE; a pending requester is served next. done arriving on the timeout cycle -> tmo_err stays 0.
- Reset mid-frame: rst_n low during WAIT -> all outputs 0 immediately (asynchronous), pend cleared, next request after release is granted to requester 0.
- UDP_SCHED_PRIO_EN defined: pend=4'b0110 and req[0] during the GAP of requester 1 -> requester 0 is granted before requester 2; rr stays 1.
